// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART frame transmitter and its receiver peer.
//   - Default bit timing (27.03 MHz / 9600 baud) and frame size.
//   - Transmitter FSM state encoding.
//   - Counter width helper.
//   Optional build macro: UART_TX_PARITY_EN adds a PARITY state (3-bit state).
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 2815;
  localparam int NUM_BYTES_DEFAULT    = 17;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } tx_state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;
`endif

  // Width needed to count 0..n-1; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
//   Bit-period counter. Counts 0..CLKS_PER_BIT-1 while enabled, wraps to 0,
//   and flags the last cycle of each bit period.
//   Ports:
//     i_clk      clock, rising edge
//     i_rst_n    asynchronous active-low reset
//     i_en       count enable
//     i_clr      synchronous clear (priority over enable)
//     o_bit_end  high in the last cycle of a bit period
// -----------------------------------------------------------------------------
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_bit_end
);

  localparam int unsigned   W    = cnt_width(CLKS_PER_BIT);
  localparam logic [W-1:0]  LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (r_cnt == LAST) r_cnt <= '0;
      else               r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_bit_end = i_en && (r_cnt == LAST);

endmodule

// File: rtl/uart_frame_transmitter.sv
// -----------------------------------------------------------------------------
// uart_frame_transmitter
//   Serialises a NUM_BYTES-byte frame as 8N1 UART, byte 0 first, LSB first.
//   Optional build macro: UART_TX_PARITY_EN inserts an even-parity bit after
//   the 8 data bits of every byte (8E1).
//   Ports:
//     clk_i     system clock, rising edge
//     nreset_i  asynchronous active-low reset
//     start_i   frame request, sampled only in IDLE
//     values_i  frame payload, byte k = values_i[8k+7:8k]
//     tx_o      serial line, idle high (registered)
//     busy_o    frame in progress (registered)
//     done_o    one-cycle pulse on return to IDLE (registered)
// -----------------------------------------------------------------------------
module uart_frame_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int NUM_BYTES    = NUM_BYTES_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   nreset_i,
  input  logic                   start_i,
  input  logic [8*NUM_BYTES-1:0] values_i,
  output logic                   tx_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int unsigned  BW        = cnt_width(NUM_BYTES);
  localparam logic [BW-1:0] LAST_BYTE = BW'(NUM_BYTES - 1);

  tx_state_t              r_state;
  logic [8*NUM_BYTES-1:0] r_shift;
  logic [BW-1:0]          r_byte_idx;
  logic [2:0]             r_bit_idx;
  logic                   r_tx;
  logic                   r_busy;
  logic                   r_done;
`ifdef UART_TX_PARITY_EN
  logic                   r_parity;
`endif

  logic w_start_acc;
  logic w_baud_en;
  logic w_bit_end;

  assign w_start_acc = (r_state == IDLE) && start_i;
  assign w_baud_en   = (r_state != IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .i_clk     (clk_i),
    .i_rst_n   (nreset_i),
    .i_en      (w_baud_en),
    .i_clr     (w_start_acc),
    .o_bit_end (w_bit_end)
  );

  // tx is registered one step ahead: each transition loads the level of the
  // state being entered, so the line changes exactly on the bit boundary.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_byte_idx <= '0;
      r_bit_idx  <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_shift    <= values_i;
            r_byte_idx <= '0;
            r_bit_idx  <= '0;
            r_busy     <= 1'b1;
            r_tx       <= 1'b0;
            r_state    <= START;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
          end
        end
        START: begin
          if (w_bit_end) begin
            r_tx    <= r_shift[0];
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            // After 8 shifts the next byte sits in bit 0 of the register.
            r_shift <= r_shift >> 1;
`ifdef UART_TX_PARITY_EN
            r_parity <= r_parity ^ r_shift[0];
`endif
            if (r_bit_idx == 3'd7) begin
              r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              r_tx    <= r_parity ^ r_shift[0];
              r_state <= PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_bit_end) begin
            r_tx    <= 1'b1;
            r_state <= STOP;
          end
        end
`endif
        STOP: begin
          if (w_bit_end) begin
            if (r_byte_idx < LAST_BYTE) begin
              r_byte_idx <= r_byte_idx + 1'b1;
              r_bit_idx  <= '0;
              r_tx       <= 1'b0;
              r_state    <= START;
`ifdef UART_TX_PARITY_EN
              r_parity   <= 1'b0;
`endif
            end else begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx_o   = r_tx;
  assign busy_o = r_busy;
  assign done_o = r_done;

endmodule

// File: tb/tb_uart_frame_transmitter.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_transmitter
//   Directed bench for uart_frame_transmitter with a short bit period so that
//   complete 17-byte frames fit comfortably in simulation. A mid-bit sampling
//   receiver model rebuilds the frame from tx_o.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_frame_transmitter;

  localparam int CPB = 8;
  localparam int NB  = 17;
  localparam int FW  = 8 * NB;
`ifdef UART_TX_PARITY_EN
  localparam int BPB = 11;
`else
  localparam int BPB = 10;
`endif
  localparam int FRAME_CYC = NB * BPB * CPB;
  localparam int DONE_LAT  = FRAME_CYC + 1;

  logic          clk;
  logic          nreset_i;
  logic          start_i;
  logic [FW-1:0] values_i;
  logic          tx_o;
  logic          busy_o;
  logic          done_o;

  int pass_cnt  = 0;
  int check_cnt = 0;

  uart_frame_transmitter #(
    .CLKS_PER_BIT(CPB),
    .NUM_BYTES   (NB)
  ) dut (
    .clk_i    (clk),
    .nreset_i (nreset_i),
    .start_i  (start_i),
    .values_i (values_i),
    .tx_o     (tx_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a one-cycle start; returns at #1 after the sampling edge.
  task automatic kick(input logic [FW-1:0] v);
    @(negedge clk);
    values_i = v;
    start_i  = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  // Receiver model: finds each start bit, samples mid-bit, checks framing.
  task automatic rx_frame(output logic [FW-1:0] got, output int err);
    int  w;
    logic par;
    got = '0;
    err = 0;
    for (int b = 0; b < NB; b++) begin
      w = 0;
      @(negedge clk);
      while (tx_o !== 1'b0 && w < 4 * BPB * CPB) begin
        @(negedge clk);
        w++;
      end
      if (tx_o !== 1'b0) begin
        err++;
        return;
      end
      repeat (CPB / 2) @(negedge clk);
      if (tx_o !== 1'b0) err++;
      par = 1'b0;
      for (int j = 0; j < 8; j++) begin
        repeat (CPB) @(negedge clk);
        got[8*b+j] = tx_o;
        par ^= tx_o;
      end
`ifdef UART_TX_PARITY_EN
      repeat (CPB) @(negedge clk);
      if (tx_o !== par) err++;
`endif
      repeat (CPB) @(negedge clk);
      if (tx_o !== 1'b1) err++;
    end
  endtask

  // Counts from the start-sampling edge (counted as 1) until done_o is seen.
  task automatic wait_done(input bit chk_width, output int lat,
                           output bit busy_ok, output bit width_ok);
    lat      = 1;
    busy_ok  = 1'b1;
    width_ok = 1'b1;
    while (done_o !== 1'b1 && lat < DONE_LAT + 4 * CPB) begin
      if (busy_o !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    if (chk_width && done_o === 1'b1) begin
      @(posedge clk);
      #1;
      width_ok = (done_o === 1'b0);
    end
  endtask

  task automatic test_reset();
    bit active;
    nreset_i = 1'b0;
    start_i  = 1'b1;
    values_i = '1;
    #100;
    check_cnt++;
    if (tx_o !== 1'b1) $display("FAIL reset_tx got=%b exp=1", tx_o); else pass_cnt++;
    check_cnt++;
    if (busy_o !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy_o); else pass_cnt++;
    check_cnt++;
    if (done_o !== 1'b0) $display("FAIL reset_done got=%b exp=0", done_o); else pass_cnt++;
    @(negedge clk);
    nreset_i = 1'b1;
    start_i  = 1'b0;
    active   = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (tx_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) active = 1'b1;
    end
    check_cnt++;
    if (active) $display("FAIL reset_no_activity got=active exp=idle"); else pass_cnt++;
  endtask

  task automatic test_single_frame();
    logic [FW-1:0] v, got;
    int err, lat, lowlen;
    bit busy_ok, width_ok;
    v = 136'h0123456789ABCDEF_FEDCBA9876543210_A5;
    kick(v);
    fork
      rx_frame(got, err);
      wait_done(1'b1, lat, busy_ok, width_ok);
      begin
        lowlen = 1;
        while (tx_o === 1'b0 && lowlen < 4 * CPB) begin
          @(posedge clk);
          #1;
          if (tx_o === 1'b0) lowlen++;
        end
      end
    join
    check_cnt++;
    if (lowlen != CPB) $display("FAIL single_start_len got=%0d exp=%0d", lowlen, CPB); else pass_cnt++;
    check_cnt++;
    if (got[7:0] !== 8'hA5) $display("FAIL single_byte0 got=%h exp=a5", got[7:0]); else pass_cnt++;
    check_cnt++;
    if (got !== v) $display("FAIL single_frame got=%h exp=%h", got, v); else pass_cnt++;
    check_cnt++;
    if (err != 0) $display("FAIL single_framing got=%0d exp=0", err); else pass_cnt++;
    check_cnt++;
    if (lat != DONE_LAT) $display("FAIL single_done_lat got=%0d exp=%0d", lat, DONE_LAT); else pass_cnt++;
    check_cnt++;
    if (!width_ok) $display("FAIL single_done_width got=long exp=1cycle"); else pass_cnt++;
    check_cnt++;
    if (!busy_ok) $display("FAIL single_busy got=dropped exp=held"); else pass_cnt++;
  endtask

  task automatic test_loopback();
    logic [FW-1:0] v, got;
    int err, lat;
    bit busy_ok, width_ok;
    v = {$urandom(), $urandom(), $urandom(), $urandom(), 8'($urandom())};
    kick(v);
    fork
      rx_frame(got, err);
      wait_done(1'b1, lat, busy_ok, width_ok);
    join
    check_cnt++;
    if (got !== v) $display("FAIL loopback_frame got=%h exp=%h", got, v); else pass_cnt++;
    check_cnt++;
    if (err != 0) $display("FAIL loopback_framing got=%0d exp=0", err); else pass_cnt++;
    check_cnt++;
    if (lat != DONE_LAT) $display("FAIL loopback_done_lat got=%0d exp=%0d", lat, DONE_LAT); else pass_cnt++;
  endtask

  task automatic test_ignored_start();
    logic [FW-1:0] v, got;
    int err, lat;
    bit busy_ok, width_ok;
    v = 136'h5A_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;
    kick(v);
    fork
      rx_frame(got, err);
      wait_done(1'b1, lat, busy_ok, width_ok);
      begin
        repeat (FRAME_CYC / 2) @(negedge clk);
        values_i = '1;
        start_i  = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
      end
    join
    check_cnt++;
    if (got !== v) $display("FAIL ignored_frame got=%h exp=%h", got, v); else pass_cnt++;
    check_cnt++;
    if (err != 0) $display("FAIL ignored_framing got=%0d exp=0", err); else pass_cnt++;
    check_cnt++;
    if (lat != DONE_LAT) $display("FAIL ignored_done_lat got=%0d exp=%0d", lat, DONE_LAT); else pass_cnt++;
    check_cnt++;
    if (!busy_ok) $display("FAIL ignored_busy got=dropped exp=held"); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [FW-1:0] got;
    int err, lat;
    bit busy_ok, width_ok;
    kick(136'hFFEEDDCCBBAA99887766554433221100_C3);
    wait_done(1'b0, lat, busy_ok, width_ok);
    check_cnt++;
    if (lat != DONE_LAT) $display("FAIL b2b_first_lat got=%0d exp=%0d", lat, DONE_LAT); else pass_cnt++;
    check_cnt++;
    if (tx_o !== 1'b1) $display("FAIL b2b_gap_tx got=%b exp=1", tx_o); else pass_cnt++;
    values_i = '0;
    start_i  = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    check_cnt++;
    if (tx_o !== 1'b0) $display("FAIL b2b_start_bit got=%b exp=0", tx_o); else pass_cnt++;
    check_cnt++;
    if (busy_o !== 1'b1 || done_o !== 1'b0)
      $display("FAIL b2b_flags got=busy%b/done%b exp=busy1/done0", busy_o, done_o);
    else pass_cnt++;
    fork
      rx_frame(got, err);
      wait_done(1'b1, lat, busy_ok, width_ok);
    join
    check_cnt++;
    if (got !== '0 || err != 0) $display("FAIL b2b_second_frame got=%h err=%0d exp=0", got, err); else pass_cnt++;
    check_cnt++;
    if (lat != DONE_LAT) $display("FAIL b2b_second_lat got=%0d exp=%0d", lat, DONE_LAT); else pass_cnt++;
  endtask

  task automatic test_midframe_reset();
    logic [FW-1:0] v, got;
    int err, lat;
    bit busy_ok, width_ok, saw_done, active;
    kick(136'h11223344556677889900AABBCCDDEEFF_42);
    repeat (5 * BPB * CPB + 4 * CPB + 2) @(negedge clk);
    check_cnt++;
    if (busy_o !== 1'b1) $display("FAIL midreset_pre_busy got=%b exp=1", busy_o); else pass_cnt++;
    nreset_i = 1'b0;
    #1;
    check_cnt++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0)
      $display("FAIL midreset_async got=tx%b/busy%b exp=tx1/busy0", tx_o, busy_o);
    else pass_cnt++;
    saw_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done_o !== 1'b0) saw_done = 1'b1;
    end
    nreset_i = 1'b1;
    active   = 1'b0;
    repeat (3 * CPB) begin
      @(negedge clk);
      if (done_o !== 1'b0) saw_done = 1'b1;
      if (tx_o !== 1'b1 || busy_o !== 1'b0) active = 1'b1;
    end
    check_cnt++;
    if (saw_done) $display("FAIL midreset_no_done got=pulse exp=none"); else pass_cnt++;
    check_cnt++;
    if (active) $display("FAIL midreset_idle got=active exp=idle"); else pass_cnt++;
    v = 136'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0_3C;
    kick(v);
    fork
      rx_frame(got, err);
      wait_done(1'b1, lat, busy_ok, width_ok);
    join
    check_cnt++;
    if (got !== v || err != 0) $display("FAIL midreset_new_frame got=%h err=%0d exp=%h", got, err, v); else pass_cnt++;
    check_cnt++;
    if (lat != DONE_LAT) $display("FAIL midreset_new_lat got=%0d exp=%0d", lat, DONE_LAT); else pass_cnt++;
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int lat;
    bit busy_ok, width_ok;
    kick(136'h00000000000000000000000000000000_07);
    repeat (9 * CPB + CPB / 2) @(negedge clk);
    check_cnt++;
    if (tx_o !== 1'b1) $display("FAIL parity_07 got=%b exp=1", tx_o); else pass_cnt++;
    wait_done(1'b1, lat, busy_ok, width_ok);
    check_cnt++;
    if (lat != DONE_LAT - (9 * CPB + CPB / 2))
      $display("FAIL parity_lat got=%0d exp=%0d", lat, DONE_LAT - (9 * CPB + CPB / 2));
    else pass_cnt++;
  endtask
`endif

  initial begin
    nreset_i = 1'b0;
    start_i  = 1'b0;
    values_i = '0;
    test_reset();
    test_single_frame();
    test_loopback();
    test_ignored_start();
    test_back_to_back();
    test_midframe_reset();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
